// File: rtl/au_share_arb.sv
// Round-robin front end that time-shares one external add/sub unit among NREQ requesters.
// Grant in cycle t registers operands for the au; its result returns as a one-cycle pulse in cycle t+2.
module au_share_arb #(
    parameter int N    = 32,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_u,
    input  logic [NREQ-1:0]   req_sub,
    output logic [N-1:0]      au_a,
    output logic [N-1:0]      au_b,
    output logic              au_u,
    output logic              au_sub,
    input  logic [N-1:0]      au_s,
    input  logic              au_ovf,
    input  logic              au_neg,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_s,
    output logic              rsp_ovf,
    output logic              rsp_neg,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   gnt_id;
    logic            gnt_any;
    logic [NREQ-1:0] grant;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic            sel_u;
    logic            sel_sub;

    logic [PW-1:0]   id_p1;
    logic            vld_p1;
    logic [PW-1:0]   id_p2;
    logic            vld_p2;

    // Walk candidates ptr, ptr+1, ... (mod NREQ); the first valid one wins.
    always_comb begin : arbitrate
        logic [PW:0] cand;
        cand    = '0;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!reset && !gnt_any && req_valid[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        grant   = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_u   = 1'b0;
        sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = gnt_any && (gnt_id == PW'(i));
            if (grant[i]) begin
                sel_a   = req_a[i*N +: N];
                sel_b   = req_b[i*N +: N];
                sel_u   = req_u[i];
                sel_sub = req_sub[i];
            end
        end
    end

    assign ptr_nxt   = (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + PW'(1);
    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            id_p1   <= '0;
            vld_p1  <= 1'b0;
            id_p2   <= '0;
            vld_p2  <= 1'b0;
            au_a    <= '0;
            au_b    <= '0;
            au_u    <= 1'b0;
            au_sub  <= 1'b0;
            rsp_s   <= '0;
            rsp_ovf <= 1'b0;
            rsp_neg <= 1'b0;
        end else begin
            // Stage 1: operand register; au inputs only move on a grant
            vld_p1 <= gnt_any;
            if (gnt_any) begin
                ptr    <= ptr_nxt;
                id_p1  <= gnt_id;
                au_a   <= sel_a;
                au_b   <= sel_b;
                au_u   <= sel_u;
                au_sub <= sel_sub;
            end
            // Stage 2: capture the au result; held while no operation completes
            vld_p2 <= vld_p1;
            id_p2  <= id_p1;
            if (vld_p1) begin
                rsp_s   <= au_s;
                rsp_ovf <= au_ovf;
                rsp_neg <= au_neg;
            end
        end
    end

    // Gating with reset keeps a dropped in-flight result from ever being seen.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = !reset && vld_p2 && (id_p2 == PW'(i));
    end

    assign busy = !reset && (vld_p1 || vld_p2);

endmodule

// File: tb/tb_au_share_arb.sv
// Bench for au_share_arb: directed vector table, hand sequences and random traffic
// scored against a queue-based model of grants and their two-cycle-later responses.
module tb_au_share_arb;
    localparam int N    = 32;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_u = '0;
    logic [NREQ-1:0]   req_sub = '0;
    logic [N-1:0]      au_a, au_b, au_s, rsp_s;
    logic              au_u, au_sub, au_ovf, au_neg, rsp_ovf, rsp_neg, busy;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      op_a [NREQ];
    logic [N-1:0]      op_b [NREQ];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit sb_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    au_share_arb #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_u(req_u), .req_sub(req_sub),
        .au_a(au_a), .au_b(au_b), .au_u(au_u), .au_sub(au_sub),
        .au_s(au_s), .au_ovf(au_ovf), .au_neg(au_neg),
        .rsp_valid(rsp_valid), .rsp_s(rsp_s), .rsp_ovf(rsp_ovf), .rsp_neg(rsp_neg),
        .busy(busy)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = op_a[i];
            req_b[i*N +: N] = op_b[i];
        end
    end

    // Arithmetic unit: returns {s, ovf, neg}. Unsigned: ovf = carry/borrow, neg = borrow.
    // Signed: ovf = result out of range, neg = true sign of the exact result.
    function automatic logic [N+1:0] au_fn(logic [N-1:0] a, logic [N-1:0] b, logic u, logic sub);
        logic [N:0] w;
        longint sa, sb, r, lim;
        if (u) begin
            w = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
            return {w[N-1:0], w[N], sub & w[N]};
        end
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = sub ? sa - sb : sa + sb;
        lim = longint'(1) <<< (N-1);
        return {r[N-1:0], (r >= lim) || (r < -lim), r < 0};
    endfunction

    assign {au_s, au_ovf, au_neg} = au_fn(au_a, au_b, au_u, au_sub);

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of expected responses, each due two cycles after its grant.
    typedef struct {
        int          id;
        logic [N-1:0] s;
        logic        ovf;
        logic        neg;
        int          due;
    } exp_t;

    exp_t q[$];
    int   mptr = 0;

    always @(negedge clk) begin : scoreboard
        logic [NREQ-1:0] erdy, erv;
        logic [N+1:0]    r;
        exp_t            e;
        int              g;
        if (sb_on) begin
            erdy = '0;
            erv  = '0;
            g    = -1;
            if (reset) begin
                check("sb_ready_in_reset", req_ready, '0);
                check("sb_rsp_valid_in_reset", rsp_valid, '0);
                check("sb_busy_in_reset", busy, 1'b0);
                q.delete();
                mptr = 0;
            end else begin
                check("sb_busy", busy, q.size() != 0);
                if (q.size() != 0 && q[0].due == cyc) begin
                    erv[q[0].id] = 1'b1;
                    check("sb_rsp_s", rsp_s, q[0].s);
                    check("sb_rsp_ovf", rsp_ovf, q[0].ovf);
                    check("sb_rsp_neg", rsp_neg, q[0].neg);
                    void'(q.pop_front());
                end
                check("sb_rsp_valid", rsp_valid, erv);
                for (int k = 0; k < NREQ; k++)
                    if (g < 0 && req_valid[(mptr + k) % NREQ])
                        g = (mptr + k) % NREQ;
                if (g >= 0) begin
                    erdy[g] = 1'b1;
                    r     = au_fn(op_a[g], op_b[g], req_u[g], req_sub[g]);
                    e.id  = g;
                    e.s   = r[N+1:2];
                    e.ovf = r[1];
                    e.neg = r[0];
                    e.due = cyc + 2;
                    q.push_back(e);
                    mptr = (g + 1) % NREQ;
                end
                check("sb_req_ready", req_ready, erdy);
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v, u, sub, rdy, rv;
        logic [31:0] s;
        logic        ovf, neg, bsy, z;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] u, logic [3:0] sub,
                                logic [3:0] rdy, logic [3:0] rv, logic [31:0] s,
                                logic ovf, logic neg, logic bsy, logic z);
        vec_t t;
        t.rst = rst; t.v = v; t.u = u; t.sub = sub; t.rdy = rdy; t.rv = rv;
        t.s = s; t.ovf = ovf; t.neg = neg; t.bsy = bsy; t.z = z;
        return t;
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t tv [39];
    logic [NREQ-1:0] rdy_seen;

    initial begin
        // rst, valid, u, sub | ready, rsp_valid, rsp_s, ovf, neg, busy, zero-check
        tv[0]  = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[1]  = mk(0, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[2]  = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[3]  = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[4]  = mk(0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[5]  = mk(0, 4'h8, 4'hF, 4'h8, 4'h8, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[6]  = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 32'h2222_2223, 0, 0, 1, 0);
        tv[7]  = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 32'h2222_2223, 1, 1, 1, 0);
        tv[8]  = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[9]  = mk(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[10] = mk(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[11] = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h1, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[12] = mk(0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h2, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[13] = mk(0, 4'hF, 4'hF, 4'h0, 4'h1, 4'h4, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[14] = mk(0, 4'hF, 4'hF, 4'h0, 4'h2, 4'h8, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[15] = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h1, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[16] = mk(0, 4'hF, 4'hF, 4'h0, 4'h8, 4'h2, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[17] = mk(0, 4'h4, 4'hF, 4'h0, 4'h4, 4'h4, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[18] = mk(0, 4'hA, 4'hF, 4'h0, 4'h8, 4'h8, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[19] = mk(0, 4'h2, 4'hF, 4'h0, 4'h2, 4'h4, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[20] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[21] = mk(0, 4'hF, 4'hF, 4'h0, 4'h4, 4'h2, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[22] = mk(0, 4'hB, 4'hF, 4'h0, 4'h8, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[23] = mk(0, 4'h3, 4'hF, 4'h0, 4'h1, 4'h4, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[24] = mk(0, 4'h2, 4'hF, 4'h0, 4'h2, 4'h8, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[25] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[26] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 32'hFFFF_FFFF, 0, 0, 1, 0);
        tv[27] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[28] = mk(0, 4'h1, 4'hF, 4'h0, 4'h1, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[29] = mk(0, 4'h2, 4'hF, 4'h0, 4'h2, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[30] = mk(1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0);
        tv[31] = mk(0, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0, 32'h0, 0, 0, 0, 1);
        tv[32] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 1, 0);
        tv[33] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 32'hFFFF_FFFF, 0, 0, 1, 0);
        for (int k = 34; k < 39; k++)
            tv[k] = mk(0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 32'h1111_1111;
            op_b[i] = 32'hEEEE_EEEE;
        end
        repeat (2) @(posedge clk);
        sb_on = 1'b1;

        for (int k = 0; k < 39; k++) begin
            @(posedge clk);
            #1;
            reset     = tv[k].rst;
            req_valid = tv[k].v;
            req_u     = tv[k].u;
            req_sub   = tv[k].sub;
            @(negedge clk);
            check("tbl_req_ready", req_ready, tv[k].rdy);
            check("tbl_rsp_valid", rsp_valid, tv[k].rv);
            check("tbl_busy", busy, tv[k].bsy);
            if (tv[k].rv != 4'h0) begin
                check("tbl_rsp_s", rsp_s, tv[k].s);
                check("tbl_rsp_ovf", rsp_ovf, tv[k].ovf);
                check("tbl_rsp_neg", rsp_neg, tv[k].neg);
            end
            if (tv[k].z) begin
                check("rst_au_ab", {au_a, au_b}, 64'h0);
                check("rst_au_ctl", {au_u, au_sub}, 2'b00);
                check("rst_rsp", {rsp_s, rsp_ovf, rsp_neg}, 34'h0);
            end
        end

        // Idle hold: operands and result registers keep their last values.
        check("idle_au_a", au_a, 32'h1111_1111);
        check("idle_au_b", au_b, 32'hEEEE_EEEE);
        check("idle_rsp_s", rsp_s, 32'hFFFF_FFFF);
        check("idle_busy", busy, 1'b0);

        // Pointer unchanged by idle cycles: requester 3 alone is granted next.
        @(posedge clk); #1;
        req_valid = 4'b1000;
        @(negedge clk);
        check("idle_ptr_grant3", req_ready, 4'b1000);

        // Single requester valid every cycle with changing operands: two or more in flight.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 4'b0001;
            op_a[0]   = 32'h0000_1000 + k;
            op_b[0]   = 32'h0000_0010 * k;
            req_u[0]  = k[0];
            req_sub[0] = k[1];
            @(negedge clk);
            check("single_grant", req_ready, 4'b0001);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Random traffic: each requester holds its request until granted.
        rdy_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || rdy_seen[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    op_a[i]      = pick();
                    op_b[i]      = pick();
                    req_u[i]     = $urandom_range(0, 1) != 0;
                    req_sub[i]   = $urandom_range(0, 1) != 0;
                end
            end
            @(negedge clk);
            rdy_seen = req_ready;
        end

        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = '0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
